pipeline_stall_controller: RTL and testbench
============================================

// Module: pipeline_stall_controller
// PURPOSE
//  Hazard and stall sequencer for the 5-stage pipeline. Drives the en/clear inputs of the
//  fetch, decode, execute and memory pipeline register files. On a data-cache miss it freezes
//  the pipeline, runs a line-refill handshake with main memory, then releases the pipeline.
//  Load-use stalls and taken-branch flushes are resolved here when no miss is pending.
// PARAMETERS
//  DATA_WIDTH  32  address/data width
//  LINE_WORDS  4   words per cache line (power of 2, >=2)
//  CNT_WIDTH   16  width of the performance counters
// PORTS
//  clk              in   1                  clock; all state updates on posedge
//  rst_n            in   1                  asynchronous active-low reset
//  cache_miss_i     in   1                  memory-stage data cache miss
//  miss_addr_i      in   DATA_WIDTH         byte address of the missing access
//  load_use_i       in   1                  load-use hazard detected in decode
//  branch_taken_i   in   1                  execute-stage branch/jump taken
//  mem_gnt_i        in   1                  memory accepted the refill request
//  mem_rvalid_i     in   1                  refill data beat valid
//  mem_req_o        out  1                  refill request, held until grant
//  mem_addr_o       out  DATA_WIDTH         line-aligned refill address
//  refill_we_o      out  1                  write current beat into cache line
//  refill_idx_o     out  $clog2(LINE_WORDS) word index of current beat
//  en_fetch_o/en_decode_o/en_execute_o/en_memory_o  out 1 each  register enables
//  clear_decode_o/clear_execute_o  out 1 each  register flushes
//  busy_o           out  1                  high in any state other than IDLE
//  miss_count_o     out  CNT_WIDTH          refills started, saturating
//  stall_count_o    out  CNT_WIDTH          cycles with en_memory_o low, saturating
// BEHAVIOUR
//  - States: IDLE, REQ, REFILL, DONE. Reset (async, rst_n low): state=IDLE, beat counter=0,
//    line address=0, both counters=0. Outputs: en_*=1, clear_*=0, mem_req_o=0,
//    refill_we_o=0, busy_o=0. mem_addr_o, refill_idx_o=0.
//  - Outputs are decoded combinationally from state and current inputs.
//  - IDLE, cache_miss_i=1: all en_*=0 in that same cycle; clear_*=0. Line address latched as
//    miss_addr_i with the low $clog2(LINE_WORDS)+2 bits zeroed. miss_count_o+1. Next state REQ.
//    A miss takes priority over branch_taken_i and load_use_i (both ignored that cycle).
//  - IDLE, no miss, branch_taken_i=1: clear_decode_o=clear_execute_o=1, all en_*=1.
//    Branch beats load_use_i.
//  - IDLE, load_use_i only: en_fetch_o=en_decode_o=0, clear_execute_o=1, en_execute_o and
//    en_memory_o stay 1.
//  - REQ: mem_req_o=1, mem_addr_o=line address, all en_*=0. Request held until mem_gnt_i.
//    A grant moves to REFILL with beat counter=0. A beat arriving in the grant cycle is ignored.
//  - REFILL: mem_req_o=0, all en_*=0. On each mem_rvalid_i: refill_we_o=1,
//    refill_idx_o=beat counter, counter+1. A beat at index LINE_WORDS-1 moves to DONE and the
//    counter wraps to 0. Idle cycles with no rvalid are allowed and have no limit.
//  - DONE: one cycle, all en_*=0. The replayed access hits next cycle. Next state IDLE.
//    cache_miss_i is ignored in DONE.
//  - cache_miss_i, load_use_i and branch_taken_i are ignored outside IDLE. Stalled stages hold
//    them, so they are re-evaluated in IDLE.
//  - mem_rvalid_i outside REFILL: ignored, no write.
//  - Counters increment with DATA_WIDTH-independent unsigned arithmetic and saturate at all-ones.
//  - Reset mid-operation (any state): outputs return to reset values immediately (async).
//    An in-flight refill is abandoned and the partial line is not marked valid.
//  - Miss-to-release latency with a grant in G cycles and back-to-back beats:
//    1 (IDLE) + G (REQ) + LINE_WORDS (REFILL) + 1 (DONE) cycles with en_memory_o low.
// TESTING
//  1. Reset, then idle 5 cycles -> en_*=1, clear_*=0, busy_o=0, both counters=0.
//  2. Miss at 0x0000_104C, grant after 2 cycles, 4 back-to-back beats ->
//     mem_addr_o=0x0000_1040; refill_idx 0,1,2,3; en_memory_o low 8 cycles;
//     stall_count_o=8; miss_count_o=1.
//  3. Refill with a 3-cycle gap between beats 1 and 2 -> no refill_we_o during the gap;
//     DONE entered only after beat 3.
//  4. Same cycle: branch_taken_i=1 and load_use_i=1 -> clear_decode=clear_execute=1, all en=1.
//     Same cycle: cache_miss_i=1 and branch_taken_i=1 -> all en=0, no clears, state REQ.
//  5. rst_n low during REFILL after beat 1 -> IDLE immediately; next miss restarts at idx 0.
//  6. Force miss_count_o to 0xFFFF, then one more miss -> stays 0xFFFF.

Source files
------------

// File: rtl/pipeline_stall_controller.sv
// -----------------------------------------------------------------------------
// pipeline_stall_controller
//
// Hazard and stall sequencer for the 5-stage pipeline. It drives the enable and
// flush inputs of the fetch/decode/execute/memory pipeline registers. A data
// cache miss freezes the whole pipeline, runs a line-refill handshake with main
// memory (request/grant, then LINE_WORDS data beats) and releases the pipeline
// one cycle after the last beat. Load-use stalls and taken-branch flushes are
// handled only while no miss is being serviced.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   cache_miss_i, miss_addr_i  memory-stage miss and its byte address
//   load_use_i                 load-use hazard detected in decode
//   branch_taken_i             execute-stage branch/jump taken
//   mem_gnt_i, mem_rvalid_i    refill request accepted / data beat valid
//   mem_req_o, mem_addr_o      refill request and line-aligned address
//   refill_we_o, refill_idx_o  cache line write strobe and word index
//   en_*_o, clear_*_o          pipeline register enables and flushes
//   busy_o                     sequencer is not in IDLE
//   miss_count_o               refills started (saturating)
//   stall_count_o              cycles with en_memory_o low (saturating)
// -----------------------------------------------------------------------------
module pipeline_stall_controller #(
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WORDS = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cache_miss_i,
    input  logic [DATA_WIDTH-1:0]         miss_addr_i,
    input  logic                          load_use_i,
    input  logic                          branch_taken_i,
    input  logic                          mem_gnt_i,
    input  logic                          mem_rvalid_i,
    output logic                          mem_req_o,
    output logic [DATA_WIDTH-1:0]         mem_addr_o,
    output logic                          refill_we_o,
    output logic [$clog2(LINE_WORDS)-1:0] refill_idx_o,
    output logic                          en_fetch_o,
    output logic                          en_decode_o,
    output logic                          en_execute_o,
    output logic                          en_memory_o,
    output logic                          clear_decode_o,
    output logic                          clear_execute_o,
    output logic                          busy_o,
    output logic [CNT_WIDTH-1:0]          miss_count_o,
    output logic [CNT_WIDTH-1:0]          stall_count_o
);

    localparam int IDX_W    = $clog2(LINE_WORDS);
    // Byte offset inside a line: word index bits plus the 2 byte-in-word bits.
    localparam int OFF_BITS = IDX_W + 2;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_REQ    = 2'd1;
    localparam logic [1:0] ST_REFILL = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [IDX_W-1:0]     LAST_BEAT = IDX_W'(LINE_WORDS - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};

    logic [1:0]            state_reg, state_next;
    logic [IDX_W-1:0]      beat_reg, beat_next;
    logic [DATA_WIDTH-1:0] line_addr_reg, line_addr_next;
    logic [CNT_WIDTH-1:0]  miss_cnt_reg, miss_cnt_next;
    logic [CNT_WIDTH-1:0]  stall_cnt_reg, stall_cnt_next;
    logic [DATA_WIDTH-1:0] aligned_addr;
    logic                  miss_start;
    logic                  mem_stalled;

    // Line-align the miss address by zeroing the in-line byte offset.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_align
            assign aligned_addr[gi] = (gi < OFF_BITS) ? 1'b0 : miss_addr_i[gi];
        end
    endgenerate

    // A miss is only accepted in IDLE; elsewhere the stalled stage holds it.
    assign miss_start  = (state_reg == ST_IDLE) && cache_miss_i;
    // en_memory_o is low in every non-IDLE state and in the IDLE miss cycle.
    assign mem_stalled = (state_reg != ST_IDLE) || cache_miss_i;

    always_comb begin
        state_next      = state_reg;
        beat_next       = beat_reg;
        line_addr_next  = line_addr_reg;
        en_fetch_o      = 1'b1;
        en_decode_o     = 1'b1;
        en_execute_o    = 1'b1;
        en_memory_o     = 1'b1;
        clear_decode_o  = 1'b0;
        clear_execute_o = 1'b0;
        mem_req_o       = 1'b0;
        refill_we_o     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (cache_miss_i) begin
                    en_fetch_o     = 1'b0;
                    en_decode_o    = 1'b0;
                    en_execute_o   = 1'b0;
                    en_memory_o    = 1'b0;
                    line_addr_next = aligned_addr;
                    state_next     = ST_REQ;
                end else if (branch_taken_i) begin
                    // The flush also removes any load-use victim in decode.
                    clear_decode_o  = 1'b1;
                    clear_execute_o = 1'b1;
                end else if (load_use_i) begin
                    // Hold fetch/decode, insert a bubble into execute.
                    en_fetch_o      = 1'b0;
                    en_decode_o     = 1'b0;
                    clear_execute_o = 1'b1;
                end
            end
            ST_REQ: begin
                en_fetch_o   = 1'b0;
                en_decode_o  = 1'b0;
                en_execute_o = 1'b0;
                en_memory_o  = 1'b0;
                mem_req_o    = 1'b1;
                if (mem_gnt_i) begin
                    state_next = ST_REFILL;
                    beat_next  = '0;
                end
            end
            ST_REFILL: begin
                en_fetch_o   = 1'b0;
                en_decode_o  = 1'b0;
                en_execute_o = 1'b0;
                en_memory_o  = 1'b0;
                if (mem_rvalid_i) begin
                    refill_we_o = 1'b1;
                    if (beat_reg == LAST_BEAT) begin
                        beat_next  = '0;
                        state_next = ST_DONE;
                    end else begin
                        beat_next = beat_reg + IDX_W'(1);
                    end
                end
            end
            ST_DONE: begin
                en_fetch_o   = 1'b0;
                en_decode_o  = 1'b0;
                en_execute_o = 1'b0;
                en_memory_o  = 1'b0;
                state_next   = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        miss_cnt_next  = miss_cnt_reg;
        stall_cnt_next = stall_cnt_reg;
        if (miss_start && (miss_cnt_reg != CNT_MAX)) begin
            miss_cnt_next = miss_cnt_reg + CNT_WIDTH'(1);
        end
        if (mem_stalled && (stall_cnt_reg != CNT_MAX)) begin
            stall_cnt_next = stall_cnt_reg + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            beat_reg      <= '0;
            line_addr_reg <= '0;
            miss_cnt_reg  <= '0;
            stall_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            beat_reg      <= beat_next;
            line_addr_reg <= line_addr_next;
            miss_cnt_reg  <= miss_cnt_next;
            stall_cnt_reg <= stall_cnt_next;
        end
    end

    assign busy_o        = (state_reg != ST_IDLE);
    assign mem_addr_o    = line_addr_reg;
    assign refill_idx_o  = beat_reg;
    assign miss_count_o  = miss_cnt_reg;
    assign stall_count_o = stall_cnt_reg;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// -----------------------------------------------------------------------------
// tb_pipeline_stall_controller
//
// Directed bench for pipeline_stall_controller. Each cycle step pushes the
// expected output vector onto a scoreboard queue, then pops and compares it
// against the DUT mid-cycle. A second instance with 3-bit counters shares the
// stimulus so counter saturation can be reached in a few refills.
// -----------------------------------------------------------------------------
module tb_pipeline_stall_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cache_miss, load_use, branch_taken, mem_gnt, mem_rvalid;
    logic [31:0] miss_addr;

    logic        mem_req, refill_we, en_f, en_d, en_e, en_m, clr_d, clr_e, busy;
    logic [31:0] mem_addr;
    logic [1:0]  refill_idx;
    logic [15:0] miss_cnt, stall_cnt;

    logic        s_mem_req, s_refill_we, s_en_f, s_en_d, s_en_e, s_en_m;
    logic        s_clr_d, s_clr_e, s_busy;
    logic [31:0] s_mem_addr;
    logic [1:0]  s_refill_idx;
    logic [2:0]  s_miss_cnt, s_stall_cnt;

    always #5 clk = ~clk;

    pipeline_stall_controller #(.DATA_WIDTH(32), .LINE_WORDS(4), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .cache_miss_i(cache_miss), .miss_addr_i(miss_addr),
        .load_use_i(load_use), .branch_taken_i(branch_taken), .mem_gnt_i(mem_gnt),
        .mem_rvalid_i(mem_rvalid), .mem_req_o(mem_req), .mem_addr_o(mem_addr),
        .refill_we_o(refill_we), .refill_idx_o(refill_idx), .en_fetch_o(en_f),
        .en_decode_o(en_d), .en_execute_o(en_e), .en_memory_o(en_m),
        .clear_decode_o(clr_d), .clear_execute_o(clr_e), .busy_o(busy),
        .miss_count_o(miss_cnt), .stall_count_o(stall_cnt)
    );

    pipeline_stall_controller #(.DATA_WIDTH(32), .LINE_WORDS(4), .CNT_WIDTH(3)) dut_sat (
        .clk(clk), .rst_n(rst_n), .cache_miss_i(cache_miss), .miss_addr_i(miss_addr),
        .load_use_i(load_use), .branch_taken_i(branch_taken), .mem_gnt_i(mem_gnt),
        .mem_rvalid_i(mem_rvalid), .mem_req_o(s_mem_req), .mem_addr_o(s_mem_addr),
        .refill_we_o(s_refill_we), .refill_idx_o(s_refill_idx), .en_fetch_o(s_en_f),
        .en_decode_o(s_en_d), .en_execute_o(s_en_e), .en_memory_o(s_en_m),
        .clear_decode_o(s_clr_d), .clear_execute_o(s_clr_e), .busy_o(s_busy),
        .miss_count_o(s_miss_cnt), .stall_count_o(s_stall_cnt)
    );

    typedef struct packed {
        logic [3:0] en;    // {fetch, decode, execute, memory}
        logic [1:0] clr;   // {decode, execute}
        logic       req;
        logic       we;
        logic [1:0] idx;
        logic       busy;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   exp_miss = 0, exp_stall = 0, exp_miss3 = 0, exp_stall3 = 0;
    int   mem_low_cycles = 0;

    function automatic int sat_inc(input int v, input int max);
        return (v >= max) ? max : v + 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, queue expectation, compare mid-cycle.
    task automatic step(input logic miss, input logic lu, input logic br,
                        input logic gnt, input logic rv,
                        input logic [3:0] en, input logic [1:0] clr, input logic req,
                        input logic we, input logic [1:0] idx, input logic bsy,
                        input string tag);
        exp_t e;
        cache_miss = miss; load_use = lu; branch_taken = br; mem_gnt = gnt; mem_rvalid = rv;
        e.en = en; e.clr = clr; e.req = req; e.we = we; e.idx = idx; e.busy = bsy;
        exp_q.push_back(e);
        #2;
        e = exp_q.pop_front();
        chk({tag, "_en"},   {28'd0, en_f, en_d, en_e, en_m}, {28'd0, e.en});
        chk({tag, "_clr"},  {30'd0, clr_d, clr_e},           {30'd0, e.clr});
        chk({tag, "_req"},  {31'd0, mem_req},                {31'd0, e.req});
        chk({tag, "_we"},   {31'd0, refill_we},              {31'd0, e.we});
        chk({tag, "_idx"},  {30'd0, refill_idx},             {30'd0, e.idx});
        chk({tag, "_busy"}, {31'd0, busy},                   {31'd0, e.busy});
        $display("step %-10s miss=%b lu=%b br=%b gnt=%b rv=%b en=%b%b%b%b clr=%b%b req=%b we=%b idx=%0d busy=%b",
                 tag, miss, lu, br, gnt, rv, en_f, en_d, en_e, en_m, clr_d, clr_e,
                 mem_req, refill_we, refill_idx, busy);
        if (!e.en[0]) begin
            exp_stall      = sat_inc(exp_stall, 65535);
            exp_stall3     = sat_inc(exp_stall3, 7);
            mem_low_cycles = mem_low_cycles + 1;
        end
        @(negedge clk);
    endtask

    task automatic check_counters(input string tag);
        chk({tag, "_miss"},   {16'd0, miss_cnt},    exp_miss);
        chk({tag, "_stall"},  {16'd0, stall_cnt},   exp_stall);
        chk({tag, "_miss3"},  {29'd0, s_miss_cnt},  exp_miss3);
        chk({tag, "_stall3"}, {29'd0, s_stall_cnt}, exp_stall3);
    endtask

    // Full miss/refill transaction. Grant arrives in the g-th REQ cycle;
    // gap_len idle cycles are inserted before beat gap_before (if gap_before >= 0).
    task automatic refill(input logic [31:0] addr, input logic br_on_miss, input int g,
                          input int gap_before, input int gap_len, input string tag);
        miss_addr = addr;
        step(1, 1, br_on_miss, 0, 1, 4'b0000, 2'b00, 0, 0, 2'd0, 0, {tag, "_miss"});
        exp_miss  = sat_inc(exp_miss, 65535);
        exp_miss3 = sat_inc(exp_miss3, 7);
        miss_addr = ~addr;   // line address must already be latched
        for (int i = 0; i < g; i++) begin
            if (i == 0) chk({tag, "_addr"}, mem_addr, addr & 32'hFFFF_FFF0);
            // A beat in the grant cycle is ignored; hazards are ignored outside IDLE.
            step(1, 1, 1, (i == g - 1), (i == g - 1), 4'b0000, 2'b00, 1, 0, 2'd0, 1,
                 {tag, "_req"});
        end
        for (int b = 0; b < 4; b++) begin
            if (b == gap_before) begin
                for (int k = 0; k < gap_len; k++) begin
                    step(1, 0, 0, 0, 0, 4'b0000, 2'b00, 0, 0, 2'(b), 1, {tag, "_gap"});
                end
            end
            step(0, 0, 0, 0, 1, 4'b0000, 2'b00, 0, 1, 2'(b), 1, {tag, "_beat"});
        end
        // DONE: a miss and a stray beat here must both be ignored.
        step(1, 0, 0, 0, 1, 4'b0000, 2'b00, 0, 0, 2'd0, 1, {tag, "_done"});
        step(0, 0, 0, 0, 1, 4'b1111, 2'b00, 0, 0, 2'd0, 0, {tag, "_rel"});
        check_counters(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        cache_miss = 0; load_use = 0; branch_taken = 0; mem_gnt = 0; mem_rvalid = 0;
        miss_addr = 32'd0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: idle after reset
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0, 0, 4'b1111, 2'b00, 0, 0, 2'd0, 0, "idle");
        end
        check_counters("t1");

        // 2: miss at 0x104C, grant in second REQ cycle, back-to-back beats
        mem_low_cycles = 0;
        refill(32'h0000_104C, 0, 2, -1, 0, "t2");
        chk("t2_addr_lit", mem_addr, 32'h0000_1040);
        chk("t2_memlow", mem_low_cycles, 8);
        chk("t2_stall_lit", {16'd0, stall_cnt}, 8);
        chk("t2_miss_lit", {16'd0, miss_cnt}, 1);

        // 3: 3-cycle gap between beats 1 and 2
        refill(32'h0000_2004, 0, 1, 2, 3, "t3");

        // 4: hazard priorities in IDLE (stray rvalid must not write)
        step(0, 1, 1, 0, 1, 4'b1111, 2'b11, 0, 0, 2'd0, 0, "br_lu");
        step(0, 0, 1, 0, 0, 4'b1111, 2'b11, 0, 0, 2'd0, 0, "br");
        step(0, 1, 0, 0, 0, 4'b0011, 2'b01, 0, 0, 2'd0, 0, "lu");
        refill(32'h8000_00FC, 1, 3, -1, 0, "t4");

        // 5: reset during REFILL after beat 1
        miss_addr = 32'h0000_3010;
        step(1, 0, 0, 0, 0, 4'b0000, 2'b00, 0, 0, 2'd0, 0, "t5_miss");
        step(0, 0, 0, 1, 0, 4'b0000, 2'b00, 1, 0, 2'd0, 1, "t5_req");
        step(0, 0, 0, 0, 1, 4'b0000, 2'b00, 0, 1, 2'd0, 1, "t5_beat");
        step(0, 0, 0, 0, 1, 4'b0000, 2'b00, 0, 1, 2'd1, 1, "t5_beat");
        mem_rvalid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_busy", {31'd0, busy}, 32'd0);
        chk("t5_rst_we", {31'd0, refill_we}, 32'd0);
        chk("t5_rst_idx", {30'd0, refill_idx}, 32'd0);
        chk("t5_rst_en", {28'd0, en_f, en_d, en_e, en_m}, 32'hF);
        chk("t5_rst_addr", mem_addr, 32'd0);
        exp_miss = 0; exp_stall = 0; exp_miss3 = 0; exp_stall3 = 0;
        check_counters("t5_rst");
        @(negedge clk);
        rst_n = 1'b1;
        mem_rvalid = 1'b0;
        refill(32'h0000_3010, 0, 1, -1, 0, "t5_new");

        // 6: saturation of the 3-bit counters while the 16-bit ones keep counting
        for (int n = 0; n < 8; n++) begin
            refill(32'h0001_0000 + 32'(n * 16), 0, 1, -1, 0, "t6");
        end
        chk("t6_miss3_sat", {29'd0, s_miss_cnt}, 32'd7);
        chk("t6_miss_exact", {16'd0, miss_cnt}, 32'd9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
